if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit five-stage CPU.
- Owns the PC register and drives the PC to the instruction memory. Instruction memory is combinational (pc in, inst out the same cycle).
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles branch redirect, hazard stall, and structural bubbles when the MEM stage occupies the shared RAM. Keeps a saturating bubble counter.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0800, encoding injected into IF/ID on a bubble or kill.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID this cycle.
- mem_busy  input  1  MEM stage owns the shared RAM; inst is invalid this cycle.
- br_taken  input  1  ID-stage branch/jump resolved taken.
- br_target  input  16  redirect PC, valid when br_taken=1.
- pc  output  16  fetch address to instruction memory; combinational copy of the PC register.
- inst  input  16  instruction word from memory for the current pc.
- id_pc  output  16  PC of the instruction held in IF/ID.
- id_pc_next  output  16  id_pc+1, consumed by MFPC/JALR.
- id_inst  output  16  instruction held in IF/ID.
- id_valid  output  1  1 = id_inst is a real fetched instruction; 0 = bubble.
- bubble_cnt  output  16  count of cycles in which a bubble entered IF/ID.

Behaviour:
- Reset (rst=0, async, takes effect immediately, also mid-operation):
  - pc_reg=RESET_PC, id_pc=0, id_pc_next=0.
  - id_inst=NOP_INST, id_valid=0, bubble_cnt=0.
- After rst deasserts, the first rising edge performs a normal fetch of RESET_PC.
- PC arithmetic is word-addressed, +1 per fetch, 16-bit modulo: 16'hFFFF wraps to 16'h0000. id_pc_next wraps the same way.
- Per-edge action, evaluated in strict priority order:
  1. br_taken=1:
     - pc_reg <= br_target.
     - IF/ID <= {id_inst=NOP_INST, id_valid=0}; id_pc/id_pc_next hold.
     - Kills the wrong-path instruction. Applies regardless of stall and mem_busy.
     - bubble_cnt increments.
  2. stall=1:
     - pc_reg and all IF/ID outputs hold; bubble_cnt holds.
     - Stall wins over mem_busy so the instruction already in IF/ID is never lost.
  3. mem_busy=1:
     - pc_reg holds, so the same address is refetched next cycle.
     - IF/ID <= {NOP_INST, id_valid=0}; bubble_cnt increments.
  4. Otherwise (normal fetch):
     - id_pc <= pc_reg, id_pc_next <= pc_reg+1, id_inst <= inst, id_valid <= 1.
     - pc_reg <= pc_reg+1.
- bubble_cnt saturates at 16'hFFFF and never wraps.
- br_target equal to the current pc is legal and refetches that address next cycle.
- pc has zero latency from pc_reg.
- IF/ID latency: one clock from the pc presentation to id_inst.
- No combinational path from stall, br_taken or mem_busy to pc. pc depends only on pc_reg.

Test Plan:
- Reset then run: memory holds 0x6901 @0, 0x6A01 @1, 0x6B80 @2.
  - During reset: pc=0, id_valid=0, id_inst=0x0800.
  - After edge 1: id_pc=0, id_inst=0x6901, pc=1.
  - After edge 3: id_pc=2, id_inst=0x6B80, id_pc_next=3, pc=3.
- Stall at pc=5 for 2 cycles: pc stays 5; id_pc/id_inst unchanged; bubble_cnt unchanged. Next edge fetches 5.
- mem_busy at pc=6 for 1 cycle: pc stays 6; id_valid=0, id_inst=0x0800, bubble_cnt+1. Next edge: id_pc=6, id_valid=1.
- br_taken with br_target=4 while pc=12 and stall=1 together: next pc=4, id_valid=0, id_inst=0x0800 (branch beats stall). Following edge: id_pc=4.
- Wrap: br_target=16'hFFFF, then normal fetch: id_pc=FFFF, id_pc_next=0000, pc=0000.
- Async reset asserted mid-cycle with stall=1 and pc=9: outputs go to reset values immediately, without waiting for a clock edge.
- Saturation: preload via 65536 mem_busy cycles; bubble_cnt holds at FFFF.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage of the 16-bit five-stage CPU. Owns the PC register,
// presents it to the combinational instruction memory, and captures the
// returned word into the IF/ID pipeline register for the decode stage.
// Branch redirects kill the wrong-path fetch, hazard stalls freeze the stage,
// and cycles where MEM owns the shared RAM insert a bubble. A saturating
// counter records how many bubbles entered IF/ID.
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   NOP_INST    encoding placed in IF/ID on a bubble or kill
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   stall       hazard unit: hold PC and IF/ID this cycle
//   mem_busy    MEM stage owns the shared RAM; inst is invalid this cycle
//   br_taken    ID-stage branch/jump resolved taken
//   br_target   redirect PC, valid when br_taken = 1
//   pc          fetch address to instruction memory (copy of PC register)
//   inst        instruction word from memory for the current pc
//   id_pc       PC of the instruction held in IF/ID
//   id_pc_next  id_pc + 1, used by MFPC/JALR
//   id_inst     instruction held in IF/ID
//   id_valid    1 = id_inst is a real fetched instruction, 0 = bubble
//   bubble_cnt  saturating count of cycles in which a bubble entered IF/ID
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        mem_busy,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic [15:0] pc,
    input  logic [15:0] inst,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_next,
    output logic [15:0] id_inst,
    output logic        id_valid,
    output logic [15:0] bubble_cnt
);

    logic [15:0] pc_reg;
    logic [15:0] pc_plus_one;
    logic [15:0] pc_next;
    logic        load_bubble;
    logic        do_fetch;

    // The fetch address comes straight from the register, so no control
    // input has a combinational path to pc.
    assign pc          = pc_reg;
    assign pc_plus_one = pc_reg + 16'd1;

    // A branch kills the fetch even during a stall; otherwise a stall freezes
    // everything, and only then does a busy RAM turn the fetch into a bubble.
    assign load_bubble = br_taken | (~stall & mem_busy);
    assign do_fetch    = ~br_taken & ~stall & ~mem_busy;

    // Next PC selection in priority order: redirect, hold (stall or busy
    // RAM, so the same address is refetched), or sequential increment.
    always_comb begin
        pc_next = pc_reg;
        if (br_taken) begin
            pc_next = br_target;
        end else if (do_fetch) begin
            pc_next = pc_plus_one;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    // IF/ID register. On a bubble or kill only the instruction and valid bit
    // change; id_pc/id_pc_next keep the last fetched instruction's address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc      <= 16'h0000;
            id_pc_next <= 16'h0000;
            id_inst    <= NOP_INST;
            id_valid   <= 1'b0;
        end else if (load_bubble) begin
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (do_fetch) begin
            id_pc      <= pc_reg;
            id_pc_next <= pc_plus_one;
            id_inst    <= inst;
            id_valid   <= 1'b1;
        end
    end

    // Bubble counter, saturating at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= 16'h0000;
        end else if (load_bubble && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//
// Testbench for if_stage: a directed vector table following the fetch,
// stall, bubble, branch and wrap scenarios, an asynchronous mid-cycle reset
// sequence, a randomized run against a behavioural model, and a bubble
// counter saturation run.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        mem_busy;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] pc;
    logic [15:0] inst;
    logic [15:0] id_pc;
    logic [15:0] id_pc_next;
    logic [15:0] id_inst;
    logic        id_valid;
    logic [15:0] bubble_cnt;

    int checks;
    int failures;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .mem_busy   (mem_busy),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc         (pc),
        .inst       (inst),
        .id_pc      (id_pc),
        .id_pc_next (id_pc_next),
        .id_inst    (id_inst),
        .id_valid   (id_valid),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: the three program words at 0..2, and a
    // scrambled function of the address everywhere else.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h6901;
            16'h0001: return 16'h6A01;
            16'h0002: return 16'h6B80;
            default:  return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
        endcase
    endfunction

    // Combinational instruction memory.
    always_comb inst = mem_word(pc);

    typedef struct {
        logic        stall;
        logic        mem_busy;
        logic        br_taken;
        logic [15:0] br_target;
        logic [15:0] e_pc;
        logic [15:0] e_id_pc;
        logic [15:0] e_id_pc_next;
        logic [15:0] e_id_inst;
        logic        e_valid;
        logic [15:0] e_bub;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic m, input logic b,
                                input logic [15:0] t, input logic [15:0] epc,
                                input logic [15:0] eid, input logic [15:0] enx,
                                input logic [15:0] ein, input logic ev,
                                input logic [15:0] eb);
        vec_t v;
        v.stall = s; v.mem_busy = m; v.br_taken = b; v.br_target = t;
        v.e_pc = epc; v.e_id_pc = eid; v.e_id_pc_next = enx;
        v.e_id_inst = ein; v.e_valid = ev; v.e_bub = eb;
        return v;
    endfunction

    // Behavioural model state, updated from the fetch-stage rules.
    logic [15:0] m_pc, m_id_pc, m_id_pc_next, m_id_inst;
    logic        m_valid;
    int          m_bub;

    task automatic modelReset();
        m_pc = 16'h0000; m_id_pc = 16'h0000; m_id_pc_next = 16'h0000;
        m_id_inst = NOP; m_valid = 1'b0; m_bub = 0;
    endtask

    task automatic modelStep(input logic s, input logic m, input logic b,
                             input logic [15:0] t);
        if (b) begin
            m_id_inst = NOP; m_valid = 1'b0;
            m_bub = (m_bub < 65535) ? m_bub + 1 : 65535;
            m_pc = t;
        end else if (s) begin
            // everything holds
        end else if (m) begin
            m_id_inst = NOP; m_valid = 1'b0;
            m_bub = (m_bub < 65535) ? m_bub + 1 : 65535;
        end else begin
            m_id_pc = m_pc;
            m_id_pc_next = 16'((int'(m_pc) + 1) % 65536);
            m_id_inst = mem_word(m_pc);
            m_valid = 1'b1;
            m_pc = 16'((int'(m_pc) + 1) % 65536);
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic [15:0] epc,
                            input logic [15:0] eid, input logic [15:0] enx,
                            input logic [15:0] ein, input logic ev,
                            input logic [15:0] eb);
        checkOutput({tag, ".pc"}, pc, epc);
        checkOutput({tag, ".id_pc"}, id_pc, eid);
        checkOutput({tag, ".id_pc_next"}, id_pc_next, enx);
        checkOutput({tag, ".id_inst"}, id_inst, ein);
        checkOutput({tag, ".id_valid"}, {15'd0, id_valid}, {15'd0, ev});
        checkOutput({tag, ".bubble_cnt"}, bubble_cnt, eb);
    endtask

    // Drive one cycle of inputs, let the clock edge happen, and return #1
    // after the edge so outputs are sampled away from it.
    task automatic applyStimulus(input logic s, input logic m, input logic b,
                                 input logic [15:0] t);
        stall = s; mem_busy = m; br_taken = b; br_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        stall = 1'b0; mem_busy = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        #1;
    endtask

    vec_t vecs[21];

    initial begin
        checks = 0;
        failures = 0;

        vecs[0]  = mk(0,0,0,16'h0000, 16'h0001,16'h0000,16'h0001,16'h6901,1,16'd0);
        vecs[1]  = mk(0,0,0,16'h0000, 16'h0002,16'h0001,16'h0002,16'h6A01,1,16'd0);
        vecs[2]  = mk(0,0,0,16'h0000, 16'h0003,16'h0002,16'h0003,16'h6B80,1,16'd0);
        vecs[3]  = mk(0,0,0,16'h0000, 16'h0004,16'h0003,16'h0004,mem_word(16'd3),1,16'd0);
        vecs[4]  = mk(0,0,0,16'h0000, 16'h0005,16'h0004,16'h0005,mem_word(16'd4),1,16'd0);
        vecs[5]  = mk(1,0,0,16'h0000, 16'h0005,16'h0004,16'h0005,mem_word(16'd4),1,16'd0);
        vecs[6]  = mk(1,1,0,16'h0000, 16'h0005,16'h0004,16'h0005,mem_word(16'd4),1,16'd0);
        vecs[7]  = mk(0,0,0,16'h0000, 16'h0006,16'h0005,16'h0006,mem_word(16'd5),1,16'd0);
        vecs[8]  = mk(0,1,0,16'h0000, 16'h0006,16'h0005,16'h0006,NOP,0,16'd1);
        vecs[9]  = mk(0,0,0,16'h0000, 16'h0007,16'h0006,16'h0007,mem_word(16'd6),1,16'd1);
        vecs[10] = mk(0,0,0,16'h0000, 16'h0008,16'h0007,16'h0008,mem_word(16'd7),1,16'd1);
        vecs[11] = mk(0,0,0,16'h0000, 16'h0009,16'h0008,16'h0009,mem_word(16'd8),1,16'd1);
        vecs[12] = mk(0,0,0,16'h0000, 16'h000A,16'h0009,16'h000A,mem_word(16'd9),1,16'd1);
        vecs[13] = mk(0,0,0,16'h0000, 16'h000B,16'h000A,16'h000B,mem_word(16'd10),1,16'd1);
        vecs[14] = mk(0,0,0,16'h0000, 16'h000C,16'h000B,16'h000C,mem_word(16'd11),1,16'd1);
        vecs[15] = mk(1,0,1,16'h0004, 16'h0004,16'h000B,16'h000C,NOP,0,16'd2);
        vecs[16] = mk(0,0,0,16'h0000, 16'h0005,16'h0004,16'h0005,mem_word(16'd4),1,16'd2);
        vecs[17] = mk(0,0,1,16'hFFFF, 16'hFFFF,16'h0004,16'h0005,NOP,0,16'd3);
        vecs[18] = mk(0,0,0,16'h0000, 16'h0000,16'hFFFF,16'h0000,mem_word(16'hFFFF),1,16'd3);
        vecs[19] = mk(0,1,1,16'h0000, 16'h0000,16'hFFFF,16'h0000,NOP,0,16'd4);
        vecs[20] = mk(0,0,0,16'h0000, 16'h0001,16'h0000,16'h0001,16'h6901,1,16'd4);

        // Reset values while reset is held.
        rst = 1'b0;
        stall = 1'b0; mem_busy = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
        #12;
        checkAll("reset", 16'h0000, 16'h0000, 16'h0000, NOP, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].mem_busy, vecs[i].br_taken,
                          vecs[i].br_target);
            checkAll($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_id_pc,
                     vecs[i].e_id_pc_next, vecs[i].e_id_inst, vecs[i].e_valid,
                     vecs[i].e_bub);
        end

        // Asynchronous reset mid-cycle while stalled at pc=9.
        doReset();
        applyStimulus(0, 1, 0, 16'h0000);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 16'h0000);
        checkAll("pre_async", 16'h0009, 16'h0008, 16'h0009, mem_word(16'd8), 1'b1, 16'd1);
        stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checkAll("async_rst", 16'h0000, 16'h0000, 16'h0000, NOP, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        applyStimulus(0, 0, 0, 16'h0000);
        checkAll("post_async", 16'h0001, 16'h0000, 16'h0001, 16'h6901, 1'b1, 16'd0);

        // Randomized run against the behavioural model.
        doReset();
        for (int i = 0; i < 600; i++) begin
            logic s, m, b;
            logic [15:0] t;
            s = ($urandom_range(0, 4) == 0);
            m = ($urandom_range(0, 4) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                            : 16'($urandom);
            modelStep(s, m, b, t);
            applyStimulus(s, m, b, t);
            checkAll($sformatf("rand%0d", i), m_pc, m_id_pc, m_id_pc_next,
                     m_id_inst, m_valid, 16'(m_bub));
        end

        // Bubble counter saturation.
        doReset();
        for (int i = 0; i < 65534; i++) applyStimulus(0, 1, 0, 16'h0000);
        checkOutput("sat_fffe", bubble_cnt, 16'hFFFE);
        applyStimulus(0, 1, 0, 16'h0000);
        checkOutput("sat_ffff", bubble_cnt, 16'hFFFF);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 16'h0000);
        checkOutput("sat_hold", bubble_cnt, 16'hFFFF);
        checkOutput("sat_pc", pc, 16'h0000);
        applyStimulus(0, 0, 1, 16'h0030);
        checkOutput("sat_br", bubble_cnt, 16'hFFFF);
        checkOutput("sat_br_pc", pc, 16'h0030);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
